// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB-to-AXI bridge read path.
// Struct views use the default bus geometry (32-bit address, 4-bit len, 4-bit ID, 64-bit data).
package apb2axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  localparam int unsigned REQ_ADDR_W = 32;
  localparam int unsigned REQ_LEN_W  = 4;
  localparam int unsigned CPL_ID_W   = 4;
  localparam int unsigned CPL_DATA_W = 64;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } resp_e;

  typedef struct packed {
    logic                  is_write;
    logic [2:0]            size;
    logic [REQ_LEN_W-1:0]  len;
    logic [REQ_ADDR_W-1:0] addr;
  } rd_req_t;

  typedef struct packed {
    logic [CPL_ID_W-1:0]   id;
    logic [CPL_DATA_W-1:0] data;
    resp_e                 resp;
    logic                  len_err;
  } rd_cpl_t;

  // Worst response is the numerically largest encoding.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/apb2axi_tag_alloc.sv
// Busy bitmap for outstanding AR tags with a lowest-free-index priority encoder.
// Set and clear act on the edge; the encoder always sees the pre-edge bitmap.
module apb2axi_tag_alloc #(
  parameter int unsigned NUM_TAGS = 4,
  parameter int unsigned IDX_W    = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                i_set,
  input  logic [IDX_W-1:0]    i_set_idx,
  input  logic                i_clr,
  input  logic [IDX_W-1:0]    i_clr_idx,
  output logic [NUM_TAGS-1:0] o_busy,
  output logic                o_any_free,
  output logic [IDX_W-1:0]    o_free_idx
);

  logic [NUM_TAGS-1:0] r_busy;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_TAGS); i++) begin
        if (i_set && i_set_idx == IDX_W'(i)) begin
          r_busy[i] <= 1'b1;
        end else if (i_clr && i_clr_idx == IDX_W'(i)) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    o_free_idx = '0;
    for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
      if (!r_busy[i]) o_free_idx = IDX_W'(i);
    end
  end

  assign o_any_free = ~&r_busy;
  assign o_busy     = r_busy;

endmodule

// File: rtl/apb2axi_rd_engine.sv
// Multi-outstanding AXI read engine: pops read requests, issues tagged AR bursts, collects R beats
// per tag and emits one completion per burst. Define APB2AXI_RD_STATS_EN for saturating counters.
module apb2axi_rd_engine
  import apb2axi_pkg::*;
#(
  parameter int unsigned AXI_ADDR_W      = 32,
  parameter int unsigned AXI_DATA_W      = 64,
  parameter int unsigned AXI_ID_W        = 4,
  parameter int unsigned LEN_W           = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned FIFO_ENTRY_W    = 1 + 3 + LEN_W + AXI_ADDR_W
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    rd_pop_valid,
  output logic                    rd_pop_ready,
  input  logic [FIFO_ENTRY_W-1:0] rd_pop_data,
  output logic [AXI_ID_W-1:0]     arid,
  output logic [AXI_ADDR_W-1:0]   araddr,
  output logic [LEN_W-1:0]        arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [AXI_ID_W-1:0]     rid,
  input  logic [AXI_DATA_W-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic                    cpl_valid,
  input  logic                    cpl_ready,
  output logic [AXI_ID_W-1:0]     cpl_id,
  output logic [AXI_DATA_W-1:0]   cpl_data,
  output logic [1:0]              cpl_resp,
  output logic                    cpl_len_err,
  output logic                    err_wr_entry,
  output logic                    err_bad_rid
`ifdef APB2AXI_RD_STATS_EN
  ,
  output logic [31:0]             stat_ar_cnt,
  output logic [31:0]             stat_beat_cnt,
  output logic [31:0]             stat_err_cnt
`endif
);

  logic                  w_is_write;
  logic [2:0]            w_size;
  logic [LEN_W-1:0]      w_len;
  logic [AXI_ADDR_W-1:0] w_addr;

  assign w_is_write = rd_pop_data[FIFO_ENTRY_W-1];
  assign w_size     = rd_pop_data[FIFO_ENTRY_W-2 -: 3];
  assign w_len      = rd_pop_data[AXI_ADDR_W +: LEN_W];
  assign w_addr     = rd_pop_data[AXI_ADDR_W-1:0];

  logic                       r_active;
  logic                       r_arvalid;
  logic [AXI_ID_W-1:0]        r_arid;
  logic [AXI_ADDR_W-1:0]      r_araddr;
  logic [LEN_W-1:0]           r_arlen;
  logic [2:0]                 r_arsize;
  logic                       r_cpl_valid;
  logic [AXI_ID_W-1:0]        r_cpl_id;
  logic [AXI_DATA_W-1:0]      r_cpl_data;
  logic [1:0]                 r_cpl_resp;
  logic                       r_cpl_len_err;
  logic                       r_err_wr;
  logic                       r_err_rid;
  logic [LEN_W:0]             r_cnt  [MAX_OUTSTANDING];
  logic [1:0]                 r_resp [MAX_OUTSTANDING];
  logic [LEN_W-1:0]           r_len  [MAX_OUTSTANDING];

  logic [MAX_OUTSTANDING-1:0] w_busy;
  logic                       w_any_free;
  logic [AXI_ID_W-1:0]        w_free_idx;
  logic                       w_pop_rd, w_pop_wr, w_r_acc, w_beat_ok, w_beat_last;
  logic                       w_rid_busy, w_len_err;
  logic [LEN_W:0]             w_cur_cnt, w_new_cnt;
  logic [1:0]                 w_cur_resp, w_new_resp;
  logic [LEN_W-1:0]           w_cur_len;

  // Handshake outputs stay low until the first edge after reset release.
  assign w_pop_rd = r_active && rd_pop_valid && !w_is_write && w_any_free &&
                    (!r_arvalid || arready);
  assign w_pop_wr = r_active && rd_pop_valid && w_is_write;
  assign rd_pop_ready = w_pop_rd || w_pop_wr;
  assign rready  = r_active && (!r_cpl_valid || cpl_ready);
  assign w_r_acc = rvalid && rready;

  always_comb begin
    w_rid_busy = 1'b0;
    w_cur_cnt  = '0;
    w_cur_resp = '0;
    w_cur_len  = '0;
    for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
      if (rid == AXI_ID_W'(i)) begin
        w_rid_busy = w_busy[i];
        w_cur_cnt  = r_cnt[i];
        w_cur_resp = r_resp[i];
        w_cur_len  = r_len[i];
      end
    end
  end

  assign w_beat_ok   = w_r_acc && w_rid_busy;
  assign w_beat_last = w_beat_ok && rlast;
  assign w_new_cnt   = w_cur_cnt + (LEN_W+1)'(1);
  assign w_new_resp  = resp_max(w_cur_resp, rresp);
  assign w_len_err   = (w_new_cnt != ({1'b0, w_cur_len} + (LEN_W+1)'(1)));

  apb2axi_tag_alloc #(
    .NUM_TAGS (MAX_OUTSTANDING),
    .IDX_W    (AXI_ID_W)
  ) u_tag_alloc (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .i_set      (w_pop_rd),
    .i_set_idx  (w_free_idx),
    .i_clr      (w_beat_last),
    .i_clr_idx  (rid),
    .o_busy     (w_busy),
    .o_any_free (w_any_free),
    .o_free_idx (w_free_idx)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_active      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_arid        <= '0;
      r_araddr      <= '0;
      r_arlen       <= '0;
      r_arsize      <= '0;
      r_cpl_valid   <= 1'b0;
      r_cpl_id      <= '0;
      r_cpl_data    <= '0;
      r_cpl_resp    <= '0;
      r_cpl_len_err <= 1'b0;
      r_err_wr      <= 1'b0;
      r_err_rid     <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        r_cnt[i]  <= '0;
        r_resp[i] <= '0;
        r_len[i]  <= '0;
      end
    end else begin
      r_active  <= 1'b1;
      r_err_wr  <= w_pop_wr;
      r_err_rid <= w_r_acc && !w_rid_busy;
      if (w_pop_rd) begin
        r_arvalid <= 1'b1;
        r_arid    <= w_free_idx;
        r_araddr  <= w_addr;
        r_arlen   <= w_len;
        r_arsize  <= w_size;
      end else if (arready) begin
        r_arvalid <= 1'b0;
      end
      if (w_beat_last) begin
        r_cpl_valid   <= 1'b1;
        r_cpl_id      <= rid;
        r_cpl_data    <= rdata;
        r_cpl_resp    <= w_new_resp;
        r_cpl_len_err <= w_len_err;
      end else if (cpl_ready) begin
        r_cpl_valid <= 1'b0;
      end
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        if (w_pop_rd && w_free_idx == AXI_ID_W'(i)) begin
          r_cnt[i]  <= '0;
          r_resp[i] <= '0;
          r_len[i]  <= w_len;
        end else if (w_beat_ok && rid == AXI_ID_W'(i)) begin
          r_cnt[i]  <= w_new_cnt;
          r_resp[i] <= w_new_resp;
        end
      end
    end
  end

  assign arvalid      = r_arvalid;
  assign arid         = r_arid;
  assign araddr       = r_araddr;
  assign arlen        = r_arlen;
  assign arsize       = r_arsize;
  assign arburst      = AXI_BURST_INCR;
  assign arlock       = 1'b0;
  assign arcache      = AXI_CACHE_DEFAULT;
  assign arprot       = 3'b000;
  assign cpl_valid    = r_cpl_valid;
  assign cpl_id       = r_cpl_id;
  assign cpl_data     = r_cpl_data;
  assign cpl_resp     = r_cpl_resp;
  assign cpl_len_err  = r_cpl_len_err;
  assign err_wr_entry = r_err_wr;
  assign err_bad_rid  = r_err_rid;

`ifdef APB2AXI_RD_STATS_EN
  logic [31:0] r_stat_ar, r_stat_beat, r_stat_err;
  logic [2:0]  w_err_inc;
  logic [32:0] w_err_sum;

  assign w_err_inc = 3'(w_beat_last && (w_new_resp != 2'b00)) + 3'(w_beat_last && w_len_err) +
                     3'(w_r_acc && !w_rid_busy) + 3'(w_pop_wr);
  assign w_err_sum = {1'b0, r_stat_err} + 33'(w_err_inc);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_stat_ar   <= '0;
      r_stat_beat <= '0;
      r_stat_err  <= '0;
    end else begin
      if (r_arvalid && arready && !(&r_stat_ar)) r_stat_ar <= r_stat_ar + 32'd1;
      if (w_r_acc && !(&r_stat_beat))            r_stat_beat <= r_stat_beat + 32'd1;
      r_stat_err <= w_err_sum[32] ? '1 : w_err_sum[31:0];
    end
  end

  assign stat_ar_cnt   = r_stat_ar;
  assign stat_beat_cnt = r_stat_beat;
  assign stat_err_cnt  = r_stat_err;
`endif

endmodule

// File: tb/tb_apb2axi_rd_engine.sv
// Directed scoreboard bench for apb2axi_rd_engine (default parameters, stats disabled).
module tb_apb2axi_rd_engine;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 4;
  localparam int unsigned LW = 4;
  localparam int unsigned EW = 1 + 3 + LW + AW;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          rd_pop_valid, rd_pop_ready;
  logic [EW-1:0] rd_pop_data;
  logic [IW-1:0] arid;
  logic [AW-1:0] araddr;
  logic [LW-1:0] arlen;
  logic [2:0]    arsize, arprot;
  logic [1:0]    arburst;
  logic          arlock, arvalid, arready;
  logic [3:0]    arcache;
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready;
  logic          cpl_valid, cpl_ready;
  logic [IW-1:0] cpl_id;
  logic [DW-1:0] cpl_data;
  logic [1:0]    cpl_resp;
  logic          cpl_len_err, err_wr_entry, err_bad_rid;

  always #5 aclk = ~aclk;

  apb2axi_rd_engine dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .rd_pop_valid (rd_pop_valid),
    .rd_pop_ready (rd_pop_ready),
    .rd_pop_data  (rd_pop_data),
    .arid         (arid),
    .araddr       (araddr),
    .arlen        (arlen),
    .arsize       (arsize),
    .arburst      (arburst),
    .arlock       (arlock),
    .arcache      (arcache),
    .arprot       (arprot),
    .arvalid      (arvalid),
    .arready      (arready),
    .rid          (rid),
    .rdata        (rdata),
    .rresp        (rresp),
    .rlast        (rlast),
    .rvalid       (rvalid),
    .rready       (rready),
    .cpl_valid    (cpl_valid),
    .cpl_ready    (cpl_ready),
    .cpl_id       (cpl_id),
    .cpl_data     (cpl_data),
    .cpl_resp     (cpl_resp),
    .cpl_len_err  (cpl_len_err),
    .err_wr_entry (err_wr_entry),
    .err_bad_rid  (err_bad_rid)
  );

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          len_err;
  } cpl_t;

  cpl_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_cpl(input logic [IW-1:0] id, input logic [DW-1:0] data,
                          input logic [1:0] resp, input logic len_err);
    cpl_t e;
    e.id = id; e.data = data; e.resp = resp; e.len_err = len_err;
    exp_q.push_back(e);
  endtask

  // Presents one read entry; it must be accepted at once and appear on AR next cycle.
  task automatic issue(input logic [LW-1:0] len, input logic [AW-1:0] addr,
                       input logic [IW-1:0] exp_id);
    rd_pop_valid = 1'b1;
    rd_pop_data  = {1'b0, 3'd3, len, addr};
    #1;
    chk("issue_pop_ready", rd_pop_ready, 1);
    step();
    rd_pop_valid = 1'b0;
    chk("issue_arvalid", arvalid, 1);
    chk("issue_arid", arid, exp_id);
    chk("issue_arlen", arlen, len);
    chk("issue_araddr", araddr, addr);
  endtask

  task automatic beat(input logic [IW-1:0] id, input logic [DW-1:0] data,
                      input logic [1:0] resp, input logic last);
    rvalid = 1'b1; rid = id; rdata = data; rresp = resp; rlast = last;
    #1;
    chk("beat_rready", rready, 1);
    step();
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  // Bounded wait for a completion, compared against the scoreboard head, then drained.
  task automatic wait_cpl();
    cpl_t e;
    int n = 0;
    while (cpl_valid !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    chk("cpl_valid", cpl_valid, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cpl_id", cpl_id, e.id);
      chk("cpl_data", cpl_data, e.data);
      chk("cpl_resp", cpl_resp, e.resp);
      chk("cpl_len_err", cpl_len_err, e.len_err);
    end
    step();
  endtask

  int ord[4] = '{3, 1, 0, 2};

  initial begin
    aresetn = 1'b1; rd_pop_valid = 1'b0; rd_pop_data = '0; arready = 1'b1;
    rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0; cpl_ready = 1'b1;
    #2 aresetn = 1'b0;
    step(); step();
    rd_pop_valid = 1'b1;
    rd_pop_data  = {1'b0, 3'd3, 4'd0, 32'h10};
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_cpl_valid", cpl_valid, 0);
    chk("rst_pop_ready", rd_pop_ready, 0);
    chk("rst_err_wr", err_wr_entry, 0);
    chk("rst_err_rid", err_bad_rid, 0);
    rd_pop_valid = 1'b0;
    aresetn = 1'b1;
    step(); step();

    // Single 4-beat read.
    issue(4'd3, 32'h1000, 0);
    chk("t1_arsize", arsize, 3);
    chk("t1_arburst", arburst, 1);
    chk("t1_arlock", arlock, 0);
    chk("t1_arcache", arcache, 4'b0011);
    chk("t1_arprot", arprot, 0);
    step();
    for (int b = 0; b < 4; b++) begin
      if (b == 3) push_cpl(0, 64'hA0 + 64'(b), 2'd0, 1'b0);
      beat(0, 64'hA0 + 64'(b), 2'd0, b == 3);
    end
    wait_cpl();
    chk("t1_cpl_drained", cpl_valid, 0);

    // Four back-to-back ARs, then a stalled fifth entry.
    issue(4'd1, 32'h2000, 0);
    issue(4'd0, 32'h2100, 1);
    issue(4'd0, 32'h2200, 2);
    issue(4'd0, 32'h2300, 3);
    rd_pop_valid = 1'b1;
    rd_pop_data  = {1'b0, 3'd3, 4'd3, 32'h3000};
    #1;
    chk("t2_full_pop_ready", rd_pop_ready, 0);
    step();
    chk("t2_stall_pop_ready", rd_pop_ready, 0);
    chk("t2_stall_arvalid", arvalid, 0);
    push_cpl(2, 64'hB2, 2'd0, 1'b0);
    beat(2, 64'hB2, 2'd0, 1'b1);
    chk("t2_freed_pop_ready", rd_pop_ready, 1);
    wait_cpl();
    rd_pop_valid = 1'b0;
    chk("t2_reuse_arvalid", arvalid, 1);
    chk("t2_reuse_arid", arid, 2);
    chk("t2_reuse_arlen", arlen, 3);

    // Id 0 finishes after id 2 with an SLVERR beat.
    push_cpl(0, 64'hC1, 2'd2, 1'b0);
    beat(0, 64'hC0, 2'd2, 1'b0);
    beat(0, 64'hC1, 2'd0, 1'b1);
    wait_cpl();

    // Short burst on the re-issued tag 2 (len 3, only 2 beats).
    push_cpl(2, 64'hD1, 2'd1, 1'b1);
    beat(2, 64'hD0, 2'd0, 1'b0);
    beat(2, 64'hD1, 2'd1, 1'b1);
    wait_cpl();
    issue(4'd0, 32'h4000, 0);
    issue(4'd0, 32'h4100, 2);
    step();
    for (int k = 0; k < 4; k++) begin
      push_cpl(IW'(ord[k]), 64'hE0 + 64'(k), 2'(k), 1'b0);
      beat(IW'(ord[k]), 64'hE0 + 64'(k), 2'(k), 1'b1);
      wait_cpl();
    end

    // Write entry at the head is discarded.
    rd_pop_valid = 1'b1;
    rd_pop_data  = {1'b1, 3'd3, 4'd0, 32'h5000};
    #1;
    chk("t5_wr_pop_ready", rd_pop_ready, 1);
    step();
    rd_pop_valid = 1'b0;
    chk("t5_err_wr_pulse", err_wr_entry, 1);
    chk("t5_wr_no_ar", arvalid, 0);
    step();
    chk("t5_err_wr_clear", err_wr_entry, 0);
    // Beat on a non-busy RID is dropped.
    beat(7, 64'hF0, 2'd3, 1'b1);
    chk("t5_err_rid_pulse", err_bad_rid, 1);
    chk("t5_rid_no_cpl", cpl_valid, 0);
    step();
    chk("t5_err_rid_clear", err_bad_rid, 0);
    chk("t5_rid_no_cpl2", cpl_valid, 0);

    // Completion back-pressure stalls R.
    issue(4'd1, 32'h6000, 0);
    issue(4'd0, 32'h6100, 1);
    step();
    cpl_ready = 1'b0;
    beat(0, 64'h60, 2'd0, 1'b0);
    push_cpl(0, 64'h61, 2'd0, 1'b0);
    beat(0, 64'h61, 2'd0, 1'b1);
    chk("t6_cpl_valid", cpl_valid, 1);
    chk("t6_rready_low", rready, 0);
    rvalid = 1'b1; rid = 1; rdata = 64'h62; rresp = 2'd3; rlast = 1'b1;
    push_cpl(1, 64'h62, 2'd3, 1'b0);
    #1;
    chk("t6_r_stall", rready, 0);
    step();
    chk("t6_r_stall2", rready, 0);
    chk("t6_cpl_hold_id", cpl_id, 0);
    cpl_ready = 1'b1;
    #1;
    chk("t6_rready_drain", rready, 1);
    wait_cpl();
    rvalid = 1'b0;
    rlast  = 1'b0;
    wait_cpl();

    // Reset asserted with bursts in flight, a held completion and a stalled AR.
    cpl_ready = 1'b0;
    issue(4'd3, 32'h7000, 0);
    issue(4'd0, 32'h7100, 1);
    step();
    beat(1, 64'h71, 2'd0, 1'b1);
    arready = 1'b0;
    rd_pop_valid = 1'b1;
    rd_pop_data  = {1'b0, 3'd3, 4'd0, 32'h7200};
    #1;
    chk("t7_pop_ready", rd_pop_ready, 1);
    step();
    rd_pop_valid = 1'b0;
    chk("t7_arvalid", arvalid, 1);
    chk("t7_arid", arid, 1);
    step();
    chk("t7_ar_hold", arvalid, 1);
    chk("t7_araddr_hold", araddr, 32'h7200);
    rd_pop_valid = 1'b1;
    #1;
    chk("t7_pop_ar_busy", rd_pop_ready, 0);
    aresetn = 1'b0;
    #1;
    chk("t7_rst_arvalid", arvalid, 0);
    chk("t7_rst_cpl_valid", cpl_valid, 0);
    chk("t7_rst_rready", rready, 0);
    chk("t7_rst_pop_ready", rd_pop_ready, 0);
    rd_pop_valid = 1'b0;
    step();
    aresetn = 1'b1; arready = 1'b1; cpl_ready = 1'b1;
    step(); step();
    issue(4'd0, 32'h8000, 0);
    issue(4'd0, 32'h8100, 1);
    step();
    chk("t7_no_cpl", cpl_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb2axi_rd_engine.md
Name: apb2axi_rd_engine

Overview:
Parametrised successor to the single-transaction read path. It pops read-request entries from the READ FIFO and issues up to MAX_OUTSTANDING AXI AR bursts concurrently, each tagged with a unique ARID. It collects R beats per tag, checking beat count and accumulating the worst response. It emits one completion record per burst toward the APB response side.

Parameters:
AXI_ADDR_W, 32, address width
AXI_DATA_W, 64, read data width
AXI_ID_W, 4, ARID/RID width
LEN_W, 4, burst length field width (4 = AXI3, 8 = AXI4)
MAX_OUTSTANDING, 4, concurrent bursts; legal range 1..2**AXI_ID_W
FIFO_ENTRY_W, 1+3+LEN_W+AXI_ADDR_W, request entry {is_write, size, len, addr}, MSB first

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
rd_pop_valid  in  1  FIFO head valid
rd_pop_ready  out  1  pop strobe; entry consumed when valid&&ready
rd_pop_data  in  FIFO_ENTRY_W  FIFO head entry
arid/araddr/arlen/arsize  out  AXI_ID_W/AXI_ADDR_W/LEN_W/3  AR payload
arburst/arlock/arcache/arprot  out  2/1/4/3  constants: 01, 0, 0011, 000
arvalid  out  1;  arready  in  1  AR handshake
rid/rdata/rresp/rlast/rvalid  in  AXI_ID_W/AXI_DATA_W/2/1/1  R channel
rready  out  1  R accept
cpl_valid  out  1;  cpl_ready  in  1  completion handshake
cpl_id  out  AXI_ID_W  tag of completed burst
cpl_data  out  AXI_DATA_W  data of the RLAST beat
cpl_resp  out  2  worst RRESP over the burst (numeric max)
cpl_len_err  out  1  beat count != len+1
err_wr_entry  out  1  one-cycle pulse: a write entry was discarded
err_bad_rid  out  1  one-cycle pulse: beat with a non-busy RID was dropped

Behaviour:
- Reset (async assert, sync release): arvalid, rready, cpl_valid, rd_pop_ready, err pulses = 0; busy bitmap, beat counters, resp accumulators = 0. In-flight bursts are abandoned.
- Tag allocator: busy[MAX_OUTSTANDING] bitmap; lowest free index is chosen; ARID = index zero-extended.
- AR stage: a single output register. rd_pop_ready = rd_pop_valid && !is_write && any tag free && (!arvalid || arready). On pop, the register loads the fields and the selected tag, and busy[tag] is set the same edge; arvalid is asserted next cycle.
- Back-to-back ARs are allowed: 1 AR per cycle at full rate. The payload is held stable while arvalid && !arready.
- Head entry with is_write=1: popped (rd_pop_ready=1 that cycle, AR register untouched), err_wr_entry pulses next cycle.
- Per-tag state: beat counter (LEN_W+1 bits) and resp accumulator, both cleared at allocation. len is stored per tag.
- rready = !cpl_valid || cpl_ready (completion register free or draining).
- Each accepted beat with busy[rid] set: count++, resp = max(resp, rresp).
- Beat with rid >= MAX_OUTSTANDING or busy[rid]=0: accepted and dropped; err_bad_rid pulses.
- On accepted rlast with a busy tag: completion register loads id, rdata, the final resp (including this beat), and len_err = (count+1 != len+1). cpl_valid is asserted next cycle; busy[rid] clears the same edge, so the tag is reusable from the next cycle.
- Simultaneous free and allocate: the allocator sees the pre-edge bitmap, so a freed tag is not reissued in the same cycle.
- All tags busy: rd_pop_ready = 0; head entry is held.
- Completion latency: cpl_valid one cycle after the RLAST handshake, held until cpl_ready.
- Out-of-order completion across IDs is supported.

Optional Feature:
Macro APB2AXI_RD_STATS_EN.
- Defined: adds outputs stat_ar_cnt, stat_beat_cnt, stat_err_cnt (32 bits each, saturating, reset 0). err counts cpl_resp != 0, len_err, bad_rid, and wr_entry events.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- apb2axi_pkg gains: rd_req_t packed struct {is_write, size, len, addr}; AXI_BURST_INCR, AXI_CACHE_DEFAULT constants; resp_e enum (OKAY, EXOKAY, SLVERR, DECERR); rd_cpl_t struct.
- One sub-module: apb2axi_tag_alloc, holding the busy bitmap, lowest-free priority encoder, and set/clear ports.

Test Plan:
- Single read: entry addr=0x1000, len=3, size=3; 4 beats OKAY -> arid=0, arlen=3; cpl_id=0, cpl_resp=0, cpl_len_err=0; cpl_data = 4th beat.
- 4 entries with arready held high, MAX_OUTSTANDING=4 -> ARIDs 0,1,2,3 on consecutive cycles; 5th entry stalls (rd_pop_ready=0) until the first completion frees a tag.
- Out-of-order R (id 2 finishes before id 0), one beat SLVERR on id 0 -> completions id2 resp=0, then id0 resp=2.
- Short burst: len=3 but rlast on beat 2 -> cpl_len_err=1; tag freed.
- Write entry at head -> popped, no AR, err_wr_entry pulse; beat with rid=7 (non-busy) -> rready=1, err_bad_rid pulse, no completion.
- cpl_ready held low across an RLAST -> rready drops next cycle and R stalls; aresetn asserted mid-burst -> arvalid, cpl_valid, busy all 0 immediately.
